// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: bundle of the request/response handshake and the word-wide data memory bus
// around lsu_ctrl.
//   req_*   : one load/store request from execute (valid/ready handshake)
//   resp_*  : single-cycle completion pulse with extended load data or error flag
//   mem_*   : word-aligned read/write strobes, address and data to the data memory
// Modports:
//   slave  : the controller's view (takes requests, drives responses and the memory bus)
//   master : the environment's view (core issuing requests plus the memory answering reads)
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller driving a word-wide data memory for RV32I loads and stores.
// Sub-word stores are done as read-modify-write; loads are lane-selected and sign/zero-extended.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : lsu_ctrl_if.slave (request handshake, response pulse, memory bus)
// Parameters:
//   MISALIGN_TRAP : 1 = misaligned H/W access is answered with resp_err and no memory access,
//                   0 = low address bits are cleared to the natural alignment.
module lsu_ctrl #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] word_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        accept;
  logic        illegal;
  logic        misaligned;
  logic        req_err;
  logic [31:0] aligned_addr;
  logic [31:0] merged;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] word_addr;

  assign accept    = bus.req_valid && (state_q == StIdle);
  assign word_addr = {addr_q[31:2], 2'b00};
  assign req_err   = illegal | misaligned;

  // Request decode at accept time
  always_comb begin
    illegal      = 1'b0;
    misaligned   = 1'b0;
    aligned_addr = bus.req_addr;
    case (bus.req_funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      default: ;
    endcase
    // Stores have no unsigned variants
    if (bus.req_we && bus.req_funct3[2]) illegal = 1'b1;
    case (bus.req_funct3)
      3'b001, 3'b101: begin
        misaligned      = MISALIGN_TRAP && bus.req_addr[0];
        aligned_addr[0] = 1'b0;
      end
      3'b010: begin
        misaligned        = MISALIGN_TRAP && (bus.req_addr[1:0] != 2'b00);
        aligned_addr[1:0] = 2'b00;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            state_d = StResp;
          end else if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
            state_d = StWr;
          end else begin
            // Loads and sub-word stores both start with a read
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Store word: full word for SW, otherwise the captured word with one lane replaced
  always_comb begin
    merged = word_q;
    case (funct3_q[1:0])
      2'b00: begin
        case (addr_q[1:0])
          2'b00:   merged[7:0]   = wdata_q[7:0];
          2'b01:   merged[15:8]  = wdata_q[7:0];
          2'b10:   merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    byte_sel = word_q[7:0];
    case (addr_q[1:0])
      2'b00:   byte_sel = word_q[7:0];
      2'b01:   byte_sel = word_q[15:8];
      2'b10:   byte_sel = word_q[23:16];
      default: byte_sel = word_q[31:24];
    endcase
    half_sel = addr_q[1] ? word_q[31:16] : word_q[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = word_q;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == StIdle);
    // Gated with rst_n so a reset landing mid-access never lets a write through
    bus.mem_rd     = (state_q == StRd) && rst_n;
    bus.mem_wr     = (state_q == StWr) && rst_n;
    bus.mem_addr   = ((state_q == StRd) || (state_q == StWr)) ? word_addr : mem_addr_q;
    bus.mem_wdata  = (state_q == StWr) ? merged : mem_wdata_q;
    bus.resp_valid = (state_q == StResp);
    bus.resp_err   = (state_q == StResp) && err_q;
    bus.resp_rdata = ((state_q == StResp) && !we_q && !err_q) ? load_data : 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      word_q      <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        addr_q   <= aligned_addr;
        wdata_q  <= bus.req_wdata;
        err_q    <= req_err;
      end
      if (state_q == StRd) word_q <= bus.mem_rdata;
      // Keep the bus steady between strobes
      if ((state_q == StRd) || (state_q == StWr)) mem_addr_q <= word_addr;
      if (state_q == StWr) mem_wdata_q <= merged;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl against a byte-lane arithmetic model,
// with a 64-word memory behind the bus.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.MISALIGN_TRAP(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [31:0] mem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = 6'd0;
  logic [31:0] pre_data = 32'h0;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_wr === 1'b1) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    if (pre_we) mem[pre_idx] <= pre_data;
  end

  int total = 0;
  int bad = 0;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          rd_mask;
    int          wr_mask;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    bit          ready_ok;
    bit          quiet_ok;
  } obs_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          rd_mask;
    int          wr_mask;
    logic [31:0] new_word;
  } exp_t;

  // Reference: decode size/signedness from funct3 and work on the word as plain integers
  function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] word);
    exp_t   e;
    int     size;
    bit     uns;
    bit     legal;
    int     lane;
    longint v;
    longint msk;
    size = 0;
    uns = 0;
    legal = 1;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1; end
      3'd5: begin size = 2; uns = 1; end
      default: legal = 0;
    endcase
    if (we && uns) legal = 0;
    lane = int'(addr % 4);
    e.new_word = word;
    e.rdata = 32'h0;
    e.rd_mask = 0;
    e.wr_mask = 0;
    e.err = 1'b0;
    if (!legal) e.err = 1'b1;
    else if ((lane % size) != 0) e.err = 1'b1;
    if (e.err) begin
      e.lat = 1;
    end else if (!we) begin
      e.lat = 2;
      e.rd_mask = 2;
      v = longint'(word) >> (8 * lane);
      if (size < 4) begin
        v = v % (64'sd1 << (8 * size));
        if (!uns && v >= (64'sd1 << (8 * size - 1))) v = v - (64'sd1 << (8 * size));
      end
      e.rdata = v[31:0];
    end else begin
      if (size == 4) msk = 64'sh0FFFF_FFFF;
      else msk = ((64'sd1 << (8 * size)) - 1) << (8 * lane);
      v = (longint'(word) & ~msk) | ((longint'(wdata) << (8 * lane)) & msk);
      e.new_word = v[31:0];
      e.lat = (size == 4) ? 2 : 3;
      e.rd_mask = (size == 4) ? 0 : 2;
      e.wr_mask = (size == 4) ? 2 : 4;
    end
    return e;
  endfunction

  task automatic preload(input logic [5:0] idx, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1;
    pre_idx = idx;
    pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issue one request from IDLE and record what the DUT does until its response (bounded)
  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output obs_t o);
    o.lat = 0; o.err = 1'b0; o.rdata = 32'h0; o.rd_mask = 0; o.wr_mask = 0;
    o.rd_addr = 32'h0; o.wr_addr = 32'h0; o.wr_data = 32'h0; o.ready_ok = 1; o.quiet_ok = 1;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    if (bus.req_ready !== 1'b1) o.ready_ok = 0;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.req_ready !== 1'b0) o.ready_ok = 0;
      if (bus.mem_rd === 1'b1) begin o.rd_mask |= (1 << k); o.rd_addr = bus.mem_addr; end
      if (bus.mem_wr === 1'b1) begin
        o.wr_mask |= (1 << k);
        o.wr_addr = bus.mem_addr;
        o.wr_data = bus.mem_wdata;
      end
      if (bus.mem_rd === 1'b1 && bus.mem_wr === 1'b1) o.quiet_ok = 0;
      if (bus.resp_valid === 1'b1) begin
        o.lat = k;
        o.err = bus.resp_err;
        o.rdata = bus.resp_rdata;
        break;
      end else if (bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin
        o.quiet_ok = 0;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) preload(i[5:0], $urandom);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
    total++;
    if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_resp got valid=%b err=%b rdata=%h exp 0/0/0", bus.resp_valid,
               bus.resp_err, bus.resp_rdata);
    end
    total++;
    if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got rd=%b wr=%b exp 0/0", bus.mem_rd, bus.mem_wr);
    end
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", bus.req_ready); end
  endtask

  task automatic test_sw();
    obs_t o;
    drive_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, o);
    total++;
    if (o.wr_mask !== 2 || o.rd_mask !== 0) begin
      bad++; $display("FAIL sw_strobes got wr=%0h rd=%0h exp wr=2 rd=0", o.wr_mask, o.rd_mask);
    end
    total++;
    if (o.wr_addr !== 32'h10 || o.wr_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL sw_bus got addr=%h data=%h exp 00000010/deadbeef", o.wr_addr, o.wr_data);
    end
    total++;
    if (o.lat !== 2 || o.err !== 1'b0) begin
      bad++; $display("FAIL sw_resp got lat=%0d err=%b exp 2/0", o.lat, o.err);
    end
    total++;
    if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL sw_mem got=%h exp=deadbeef", mem[4]); end
  endtask

  task automatic test_sub_loads();
    obs_t        o;
    logic [2:0]  f3_tab [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad_tab [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
    logic [31:0] ex_tab [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
    for (int i = 0; i < 4; i++) begin
      drive_req(1'b0, f3_tab[i], ad_tab[i], $urandom, o);
      total++;
      if (o.rdata !== ex_tab[i] || o.lat !== 2 || o.err !== 1'b0) begin
        bad++;
        $display("FAIL subload_%0d got rdata=%h lat=%0d err=%b exp %h/2/0", i, o.rdata, o.lat,
                 o.err, ex_tab[i]);
      end
      total++;
      if (o.rd_mask !== 2 || o.rd_addr !== 32'h10 || o.wr_mask !== 0) begin
        bad++;
        $display("FAIL subload_bus_%0d got rd=%0h addr=%h wr=%0h exp 2/00000010/0", i, o.rd_mask,
                 o.rd_addr, o.wr_mask);
      end
    end
  endtask

  task automatic test_sb_rmw();
    obs_t o;
    drive_req(1'b1, 3'b000, 32'h11, 32'h12345677, o);
    total++;
    if (o.rd_mask !== 2 || o.wr_mask !== 4 || o.lat !== 3) begin
      bad++;
      $display("FAIL sb_timing got rd=%0h wr=%0h lat=%0d exp 2/4/3", o.rd_mask, o.wr_mask, o.lat);
    end
    total++;
    if (o.wr_data !== 32'hDEAD77EF) begin bad++; $display("FAIL sb_wdata got=%h exp=dead77ef", o.wr_data); end
    drive_req(1'b0, 3'b010, 32'h10, 32'h0, o);
    total++;
    if (o.rdata !== 32'hDEAD77EF) begin bad++; $display("FAIL sb_readback got=%h exp=dead77ef", o.rdata); end
  endtask

  task automatic test_errors();
    obs_t        o;
    logic        we_tab [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3_tab [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] ad_tab [4] = '{32'h21, 32'h22, 32'h20, 32'h20};
    for (int i = 0; i < 4; i++) begin
      drive_req(we_tab[i], f3_tab[i], ad_tab[i], $urandom, o);
      total++;
      if (o.lat !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
        bad++;
        $display("FAIL err_%0d got lat=%0d err=%b rdata=%h exp 1/1/0", i, o.lat, o.err, o.rdata);
      end
      total++;
      if (o.rd_mask !== 0 || o.wr_mask !== 0) begin
        bad++; $display("FAIL err_nomem_%0d got rd=%0h wr=%0h exp 0/0", i, o.rd_mask, o.wr_mask);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit seen_resp;
    preload(6'd4, 32'hCAFEF00D);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr = 32'h10;
    bus.req_wdata = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_wr !== 1'b1) begin bad++; $display("FAIL abort_in_wr got mem_wr=%b exp=1", bus.mem_wr); end
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL abort_gated got mem_wr=%b exp=0", bus.mem_wr); end
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL abort_idle got ready=%b exp=1", bus.req_ready); end
    total++;
    if (mem[4] !== 32'hCAFEF00D) begin bad++; $display("FAIL abort_mem got=%h exp=cafef00d", mem[4]); end
    seen_resp = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.resp_valid !== 1'b0) seen_resp = 1;
      @(negedge clk);
    end
    total++;
    if (seen_resp) begin bad++; $display("FAIL abort_noresp got resp_valid=1 exp=0"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] val;
    int          hs;
    int          ready_mask;
    int          resp_mask;
    val = $urandom;
    preload(6'd5, val);
    hs = 0;
    ready_mask = 0;
    resp_mask = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h14;
    for (int c = 0; c <= 10; c++) begin
      if (hs == 3) bus.req_valid = 1'b0;
      if (bus.req_ready === 1'b1) ready_mask |= (1 << c);
      if (bus.req_ready === 1'b1 && bus.req_valid === 1'b1) hs++;
      if (bus.resp_valid === 1'b1) begin
        resp_mask |= (1 << c);
        total++;
        if (bus.resp_rdata !== val) begin
          bad++; $display("FAIL b2b_data_c%0d got=%h exp=%h", c, bus.resp_rdata, val);
        end
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    total++;
    if ((ready_mask & 32'h1FF) !== 32'h049) begin
      bad++; $display("FAIL b2b_ready got=%03h exp=049", ready_mask & 32'h1FF);
    end
    total++;
    if (resp_mask !== 32'h124) begin bad++; $display("FAIL b2b_resp got=%03h exp=124", resp_mask); end
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] after;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      addr = $urandom & 32'h0F0000FF;
      wdata = $urandom;
      e = model(we, f3, addr, wdata, mem[addr[7:2]]);
      drive_req(we, f3, addr, wdata, o);
      after = mem[addr[7:2]];
      total++;
      if (o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata) begin
        bad++;
        $display("FAIL rnd_resp_%0d we=%b f3=%0d a=%h got lat=%0d err=%b rd=%h exp %0d/%b/%h", i,
                 we, f3, addr, o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
      end
      total++;
      if (o.rd_mask !== e.rd_mask || o.wr_mask !== e.wr_mask) begin
        bad++;
        $display("FAIL rnd_strobes_%0d got rd=%0h wr=%0h exp %0h/%0h", i, o.rd_mask, o.wr_mask,
                 e.rd_mask, e.wr_mask);
      end
      total++;
      if (after !== e.new_word) begin
        bad++; $display("FAIL rnd_mem_%0d got=%h exp=%h", i, after, e.new_word);
      end
      total++;
      if (!o.ready_ok || !o.quiet_ok) begin
        bad++; $display("FAIL rnd_ctrl_%0d got ready_ok=%0d quiet_ok=%0d exp 1/1", i, o.ready_ok,
                        o.quiet_ok);
      end
      if (e.rd_mask != 0) begin
        total++;
        if (o.rd_addr !== {addr[31:2], 2'b00}) begin
          bad++; $display("FAIL rnd_rdaddr_%0d got=%h exp=%h", i, o.rd_addr, {addr[31:2], 2'b00});
        end
      end
      if (e.wr_mask != 0) begin
        total++;
        if (o.wr_addr !== {addr[31:2], 2'b00} || o.wr_data !== e.new_word) begin
          bad++;
          $display("FAIL rnd_wrbus_%0d got a=%h d=%h exp %h/%h", i, o.wr_addr, o.wr_data,
                   {addr[31:2], 2'b00}, e.new_word);
        end
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    test_reset();
    test_sw();
    test_sub_loads();
    test_sb_rmw();
    test_errors();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before end of tests");
    $fatal(1);
  end

endmodule
